voice_arbiter: RTL and testbench

VOICE_ARBITER -- requirements
Module: voice_arbiter

---
 rtl/keyboard_pkg.sv | 58 +++++
 rtl/key_debounce.sv | 57 +++++
 rtl/voice_arbiter.sv | 145 ++++++++++++++
 tb/tb_voice_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_pkg
//
// Shared definitions for the four-voice keyboard arbiter:
//   - voice count, index / layer / period widths
//   - arbiter state encoding
//   - base tone half-period table (C4, D4, E4, F4 at a 50 MHz clock)
//   - pick_after(): cyclic "first set key after a given index" search
// -----------------------------------------------------------------------------
package keyboard_pkg;

    localparam int NUM_VOICES = 4;
    localparam int IDX_W      = 2;
    localparam int LAYER_W    = 3;
    localparam int PERIOD_W   = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } arb_state_t;

    // Half-period of each voice in clk cycles at 50 MHz; element [0] is C4.
    localparam logic [NUM_VOICES-1:0][PERIOD_W-1:0] BASE_HALF_PERIOD = {
        19'd71586,  // [3] F4
        19'd75843,  // [2] E4
        19'd85131,  // [1] D4
        19'd95556   // [0] C4
    };

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } voice_pick_t;

    // Search keys in cyclic order from_idx+1, from_idx+2, ..., from_idx itself
    // and return the first one that is set. Candidates are visited farthest
    // first so the nearest hit is the one that sticks. Starting from the last
    // voice makes this a plain lowest-index search.
    function automatic voice_pick_t pick_after(
        input logic [NUM_VOICES-1:0] keys,
        input logic [IDX_W-1:0]      from_idx
    );
        voice_pick_t      pick;
        logic [IDX_W-1:0] cand;
        pick.found = 1'b0;
        pick.idx   = from_idx;
        for (int k = NUM_VOICES; k >= 1; k--) begin
            cand = from_idx + IDX_W'(k);
            if (keys[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Single-bit debouncer. The stable output follows the raw input only after the
// raw value has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any
// cycle where they agree again restarts the count.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (stable and count cleared)
//   raw    - raw key input
//   stable - debounced key state
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             stable_reg;
    logic             stable_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        stable_next = stable_reg;
        cnt_next    = cnt_reg;
        if (raw == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
            stable_next = raw;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/voice_arbiter.sv
// -----------------------------------------------------------------------------
// voice_arbiter
//
// Time-slices one tone generator among four debounced key voices. A voice owns
// the generator for SLOT_CYCLES cycles (or until its key is released), then a
// one-cycle HANDOFF picks the next held key in round-robin order.
//
// Ports:
//   clk         - 50 MHz system clock
//   reset       - synchronous active-high reset
//   note[3:0]   - raw key requests, one per voice, active-high
//   layer[2:0]  - octave shift (right shift of the half-period)
//   grant_valid - high while a voice owns the tone generator
//   grant_idx   - owning voice index
//   half_period - tone half-period in clk cycles (0 when nothing is granted)
//   slot_start  - one-cycle pulse on the first cycle of each grant
// -----------------------------------------------------------------------------
module voice_arbiter
    import keyboard_pkg::*;
#(
    parameter int SLOT_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_VOICES-1:0] note,
    input  logic [LAYER_W-1:0]    layer,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [PERIOD_W-1:0]   half_period,
    output logic                  slot_start
);

    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Per-voice debouncers
    // -------------------------------------------------------------------------
    logic [NUM_VOICES-1:0] stable_keys;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_debounce
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw    (note[gi]),
            .stable (stable_keys[gi])
        );
    end

    // -------------------------------------------------------------------------
    // Arbiter state
    // -------------------------------------------------------------------------
    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [IDX_W-1:0]  grant_idx_reg;
    logic [IDX_W-1:0]  grant_idx_next;
    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [SLOT_W-1:0] slot_cnt_next;
    // Set once the first grant after reset has been issued; until then an
    // IDLE->GRANT decision takes the lowest held index instead of rotating.
    logic              rr_armed_reg;
    logic              rr_armed_next;

    voice_pick_t       pick;

    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        slot_cnt_next  = slot_cnt_reg;
        rr_armed_next  = rr_armed_reg;

        // Searching after the last voice yields the lowest held index.
        pick = pick_after(stable_keys,
                          rr_armed_reg ? grant_idx_reg : IDX_W'(NUM_VOICES - 1));

        case (state_reg)
            IDLE: begin
                slot_cnt_next = '0;
                if (pick.found) begin
                    state_next     = GRANT;
                    grant_idx_next = pick.idx;
                    rr_armed_next  = 1'b1;
                end
            end

            GRANT: begin
                // Slot expiry or release of the owning key both end the slot;
                // newly pressed keys wait for the HANDOFF decision.
                if (!stable_keys[grant_idx_reg] || (slot_cnt_reg == SLOT_LAST)) begin
                    state_next    = HANDOFF;
                    slot_cnt_next = '0;
                end else begin
                    slot_cnt_next = slot_cnt_reg + SLOT_W'(1);
                end
            end

            HANDOFF: begin
                slot_cnt_next = '0;
                if (pick.found) begin
                    state_next     = GRANT;
                    grant_idx_next = pick.idx;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next    = IDLE;
                slot_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grant_idx_reg <= '0;
            slot_cnt_reg  <= '0;
            rr_armed_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_idx_reg <= grant_idx_next;
            slot_cnt_reg  <= slot_cnt_next;
            rr_armed_reg  <= rr_armed_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The slot counter is zero only on the first cycle of a grant, so the
    // start pulse needs no extra register.
    assign grant_valid = (state_reg == GRANT);
    assign grant_idx   = grant_idx_reg;
    assign slot_start  = grant_valid && (slot_cnt_reg == '0);

    // Layer feeds the shifter directly so an octave change lands in the same
    // cycle without touching the slot timing.
    assign half_period = grant_valid ? (BASE_HALF_PERIOD[grant_idx_reg] >> layer)
                                     : '0;

endmodule

// File: tb/tb_voice_arbiter.sv
// -----------------------------------------------------------------------------
// tb_voice_arbiter
//
// Directed scenarios followed by randomized key / layer / reset traffic, every
// cycle compared against a behavioural model (sample-history debounce plus a
// mode/owner/elapsed-count slot scheduler).
// -----------------------------------------------------------------------------
module tb_voice_arbiter;

    localparam int SLOT = 8;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] note;
    logic [2:0] layer;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [18:0] half_period;
    logic       slot_start;

    always #5 clk = ~clk;

    voice_arbiter #(
        .SLOT_CYCLES     (SLOT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .note        (note),
        .layer       (layer),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .half_period (half_period),
        .slot_start  (slot_start)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int base_hp [4] = '{95556, 85131, 75843, 71586};

    // Model state
    logic [3:0] hist[$];      // most recent raw samples since reset
    logic [3:0] m_stable;
    int         m_mode;       // 0 idle, 1 granting, 2 gap
    int         m_owner;
    int         m_elapsed;    // grant cycles completed in the current slot
    bit         m_fresh;      // no grant issued since reset

    int grant_log[$];         // grant_idx observed on each slot_start

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [3:0] s, input int from);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (s[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stable  = 4'b0000;
        m_mode    = 0;
        m_owner   = 0;
        m_elapsed = 0;
        m_fresh   = 1'b1;
    endtask

    // One clock edge of the model; scheduling uses the debounced keys as they
    // were before this edge, then the new raw sample updates the debounce.
    task automatic model_step();
        int p;
        if (reset) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                p = pick(m_stable, m_fresh ? 3 : m_owner);
                if (p >= 0) begin
                    m_mode = 1; m_owner = p; m_elapsed = 0; m_fresh = 1'b0;
                end
            end
            1: begin
                m_elapsed++;
                if (m_elapsed == SLOT || !m_stable[m_owner]) m_mode = 2;
            end
            default: begin
                p = pick(m_stable, m_owner);
                if (p >= 0) begin
                    m_mode = 1; m_owner = p; m_elapsed = 0;
                end else begin
                    m_mode = 0;
                end
            end
        endcase
        hist.push_back(note);
        if (hist.size() > DEB) void'(hist.pop_front());
        if (hist.size() == DEB) begin
            for (int b = 0; b < 4; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
        end
    endtask

    // Drive inputs, clock once, then compare all outputs with the model.
    task automatic tick(input logic [3:0] n, input logic [2:0] l, input logic r);
        int exp_hp;
        note  = n;
        layer = l;
        reset = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_hp = (m_mode == 1) ? (base_hp[m_owner] >> l) : 0;
        check_val("grant_valid", int'(grant_valid), int'(m_mode == 1));
        check_val("grant_idx",   int'(grant_idx),   m_owner);
        check_val("slot_start",  int'(slot_start),  int'(m_mode == 1 && m_elapsed == 0));
        check_val("half_period", int'(half_period), exp_hp);
        if (slot_start) grant_log.push_back(int'(grant_idx));
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    initial begin
        logic [3:0] rn;
        logic [2:0] rl;
        int         hold;

        reset = 1'b1;
        note  = 4'b0000;
        layer = 3'd0;
        model_reset();
        @(negedge clk);
        tick(4'b0000, 3'd0, 1'b1);
        tick(4'b0000, 3'd0, 1'b1);
        check_val("rst_grant_valid", int'(grant_valid), 0);
        check_val("rst_grant_idx",   int'(grant_idx),   0);
        check_val("rst_half_period", int'(half_period), 0);
        check_val("rst_slot_start",  int'(slot_start),  0);

        // Single key: debounce then first grant on voice 0.
        repeat (4) tick(4'b0001, 3'd0, 1'b0);
        check_val("deb_pending_gv", int'(grant_valid), 0);
        tick(4'b0001, 3'd0, 1'b0);
        check_val("first_gv",  int'(grant_valid), 1);
        check_val("first_idx", int'(grant_idx),   0);
        check_val("first_ss",  int'(slot_start),  1);
        check_val("first_hp",  int'(half_period), 95556);
        repeat (30) tick(4'b0001, 3'd0, 1'b0);

        // Two keys alternate 0,2,0,2.
        tick(4'b0000, 3'd0, 1'b1);
        grant_log.delete();
        repeat (45) tick(4'b0101, 3'd0, 1'b0);
        check_val("rr_g0", log_at(0), 0);
        check_val("rr_g1", log_at(1), 2);
        check_val("rr_g2", log_at(2), 0);
        check_val("rr_g3", log_at(3), 2);

        // Grant on 3, then key 0 joins -> wrap to 0.
        tick(4'b0000, 3'd0, 1'b1);
        grant_log.delete();
        repeat (5) tick(4'b1000, 3'd0, 1'b0);
        repeat (20) tick(4'b1001, 3'd0, 1'b0);
        check_val("wrap_g0", log_at(0), 3);
        check_val("wrap_g1", log_at(1), 0);

        // Key 3 alone is re-granted.
        tick(4'b0000, 3'd0, 1'b1);
        grant_log.delete();
        repeat (30) tick(4'b1000, 3'd0, 1'b0);
        check_val("self_g1", log_at(1), 3);
        check_val("self_g2", log_at(2), 3);

        // Early release at slot cycle 3, nothing else held -> IDLE.
        tick(4'b0000, 3'd0, 1'b1);
        repeat (8) tick(4'b0001, 3'd0, 1'b0);
        repeat (7) tick(4'b0000, 3'd0, 1'b0);
        check_val("release_gv", int'(grant_valid), 0);
        check_val("release_hp", int'(half_period), 0);

        // Layer shift on voice 1, changed mid-slot.
        tick(4'b0000, 3'd0, 1'b1);
        repeat (5) tick(4'b0010, 3'd2, 1'b0);
        check_val("layer2_hp", int'(half_period), 21282);
        tick(4'b0010, 3'd0, 1'b0);
        check_val("layer0_hp", int'(half_period), 85131);
        check_val("layer0_ss", int'(slot_start),  0);
        repeat (12) tick(4'b0010, 3'd0, 1'b0);

        // Reset mid-slot, then a held key needs a fresh debounce.
        tick(4'b0000, 3'd0, 1'b1);
        repeat (8) tick(4'b0001, 3'd0, 1'b0);
        tick(4'b0001, 3'd0, 1'b1);
        check_val("midrst_gv",  int'(grant_valid), 0);
        check_val("midrst_idx", int'(grant_idx),   0);
        check_val("midrst_hp",  int'(half_period), 0);
        repeat (4) tick(4'b0001, 3'd0, 1'b0);
        check_val("redeb_gv", int'(grant_valid), 0);
        tick(4'b0001, 3'd0, 1'b0);
        check_val("regrant_gv", int'(grant_valid), 1);

        // Random traffic with occasional bounces, layer changes and resets.
        rn   = 4'b0000;
        rl   = 3'd0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                rn   = 4'($urandom_range(0, 15));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(4, 30));
            end
            hold--;
            if ($urandom_range(0, 15) == 0) rl = 3'($urandom_range(0, 7));
            tick(rn, rl, $urandom_range(0, 399) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
